// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types and helpers for the PWM sequencer.
//   state_t      : sequencer state (IDLE / RUN / STOP)
//   MIN_PERIOD   : shortest period the counter is allowed to run
//   clamp_period : raises a requested period to MIN_PERIOD when too short
// -----------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int unsigned MIN_PERIOD = 2;

    // A period below 2 would leave no room for a low phase after count 0, so
    // short requests are raised rather than rejected.
    function automatic int unsigned clamp_period(input int unsigned period);
        return (period < MIN_PERIOD) ? MIN_PERIOD : period;
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// -----------------------------------------------------------------------------
// pwm_period_counter
// Position counter within one PWM period; wraps period-1 -> 0.
//   Clk        : system clock, rising edge
//   Rst        : synchronous active-high reset (count -> 0)
//   advance    : count this clock (held otherwise)
//   period     : current period length in clocks (runtime value)
//   count      : registered position within the period
//   next_count : value count takes on the next edge (for aligned outputs)
//   terminal   : count is at period-1
// -----------------------------------------------------------------------------
module pwm_period_counter #(
    parameter int count_width = 7
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   advance,
    input  logic [count_width-1:0] period,
    output logic [count_width-1:0] count,
    output logic [count_width-1:0] next_count,
    output logic                   terminal
);

    assign terminal = (count == period - count_width'(1));

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_count = count;
        if (advance) begin
            next_count = terminal ? '0 : count + count_width'(1);
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            count <= '0;
        end else begin
            count <= next_count;
        end
    end

endmodule

// File: rtl/pwm_controller.sv
// -----------------------------------------------------------------------------
// pwm_controller
// Sequencer/configurator for the PWM datapath: runs the per-period counter,
// drives pwm_out, steps the sample-table address once per period and accepts
// period/duty updates that take effect only at period boundaries.
//   Clk, Rst    : clock (rising edge), synchronous active-high reset
//   en          : level-sensitive run request
//   cfg_valid   : configuration offer
//   cfg_ready   : configuration can be accepted
//   cfg_period  : requested period in clocks (values < 2 run as 2)
//   cfg_duty    : requested high time in clocks
//   pwm_out     : registered PWM output
//   count       : registered position within the current period
//   address     : registered sample-table address, wraps at table_depth
//   period_end  : last cycle of a period while not idle
//   busy        : sequencer not idle
// -----------------------------------------------------------------------------
module pwm_controller
    import pwm_pkg::*;
#(
    parameter int count_width = 7,
    parameter int max_value   = 100,
    parameter int table_depth = 100,
    parameter int addr_width  = 7
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   en,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [count_width-1:0] cfg_period,
    input  logic [count_width-1:0] cfg_duty,
    output logic                   pwm_out,
    output logic [count_width-1:0] count,
    output logic [addr_width-1:0]  address,
    output logic                   period_end,
    output logic                   busy
);

    state_t                 state;
    logic [count_width-1:0] active_period, active_duty;
    logic [count_width-1:0] shadow_period, shadow_duty;
    logic [count_width-1:0] period_next, duty_next;
    logic [count_width-1:0] next_count;
    logic                   pending;
    logic                   terminal;
    logic                   xfer;
    logic                   stop_now;
    logic                   apply_pending;
    logic                   load_direct;

    pwm_period_counter #(
        .count_width (count_width)
    ) u_counter (
        .Clk        (Clk),
        .Rst        (Rst),
        .advance    (busy),
        .period     (active_period),
        .count      (count),
        .next_count (next_count),
        .terminal   (terminal)
    );

    assign busy       = (state != IDLE);
    assign period_end = busy && terminal;
    // Pending is never left set in IDLE, so this also keeps cfg_ready high there.
    assign cfg_ready  = !pending;
    assign xfer       = cfg_valid && cfg_ready;

    always_comb begin
        stop_now      = (state == STOP) && !en && period_end;
        apply_pending = period_end && pending;
        // An offer taken on the final STOP boundary has no later boundary to
        // wait for, so it is loaded directly, exactly like an offer in IDLE.
        load_direct   = xfer && ((state == IDLE) || stop_now);
        period_next   = active_period;
        duty_next     = active_duty;
        if (load_direct) begin
            period_next = count_width'(clamp_period(32'(cfg_period)));
            duty_next   = cfg_duty;
        end else if (apply_pending) begin
            period_next = shadow_period;
            duty_next   = shadow_duty;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= IDLE;
            active_period <= count_width'(max_value);
            active_duty   <= '0;
            shadow_period <= '0;
            shadow_duty   <= '0;
            pending       <= 1'b0;
            address       <= '0;
            pwm_out       <= 1'b0;
        end else begin
            active_period <= period_next;
            active_duty   <= duty_next;

            // xfer implies pending is clear, so it never collides with apply.
            // An offer on a boundary cycle lands in shadow and waits a period.
            if (xfer && !load_direct) begin
                shadow_period <= count_width'(clamp_period(32'(cfg_period)));
                shadow_duty   <= cfg_duty;
                pending       <= 1'b1;
            end else if (apply_pending) begin
                pending <= 1'b0;
            end

            if (period_end) begin
                address <= (address == addr_width'(table_depth - 1))
                         ? '0 : address + addr_width'(1);
            end

            // pwm_out is registered with count: it reflects next_count against
            // the duty that will be active for that position.
            unique case (state)
                IDLE: begin
                    pwm_out <= en && (next_count < duty_next);
                    if (en) state <= RUN;
                end
                RUN: begin
                    pwm_out <= (next_count < duty_next);
                    if (!en) state <= STOP;
                end
                STOP: begin
                    if (en) begin
                        state   <= RUN;
                        pwm_out <= (next_count < duty_next);
                    end else if (period_end) begin
                        state   <= IDLE;
                        pwm_out <= 1'b0;
                    end else begin
                        pwm_out <= (next_count < duty_next);
                    end
                end
                default: begin
                    state   <= IDLE;
                    pwm_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_controller.sv
// -----------------------------------------------------------------------------
// tb_pwm_controller
// Scoreboard bench: the driver applies inputs on the falling edge, advances a
// behavioural model across the coming rising edge and queues the outputs the
// DUT must show afterwards; the monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_pwm_controller;

    localparam int CW    = 7;
    localparam int MAXV  = 100;
    localparam int DEPTH = 100;
    localparam int AW    = 7;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          en = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_period = '0;
    logic [CW-1:0] cfg_duty = '0;
    logic          pwm_out;
    logic [CW-1:0] count;
    logic [AW-1:0] address;
    logic          period_end;
    logic          busy;

    pwm_controller #(
        .count_width (CW),
        .max_value   (MAXV),
        .table_depth (DEPTH),
        .addr_width  (AW)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .pwm_out    (pwm_out),
        .count      (count),
        .address    (address),
        .period_end (period_end),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          pwm;
        logic [CW-1:0] cnt;
        logic [AW-1:0] addr;
        logic          pe;
        logic          bsy;
        logic          rdy;
    } snap_t;

    snap_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Behavioural model: 0 = idle, 1 = running, 2 = stopping.
    int m_state = 0;
    int m_pos   = 0;
    int m_per   = MAXV;
    int m_duty  = 0;
    int m_pend  = 0;
    int m_sper  = 0;
    int m_sduty = 0;
    int m_addr  = 0;

    function automatic snap_t model_out();
        snap_t s;
        s.pwm  = (m_state != 0) && (m_pos < m_duty);
        s.cnt  = CW'(m_pos);
        s.addr = AW'(m_addr);
        s.pe   = (m_state != 0) && (m_pos == m_per - 1);
        s.bsy  = (m_state != 0);
        s.rdy  = (m_pend == 0);
        return s;
    endfunction

    task automatic check(input string name, input snap_t got, input snap_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got pwm=%0b cnt=%0d addr=%0d pe=%0b busy=%0b rdy=%0b required pwm=%0b cnt=%0d addr=%0d pe=%0b busy=%0b rdy=%0b",
                     name, $time, got.pwm, got.cnt, got.addr, got.pe, got.bsy, got.rdy,
                     exp.pwm, exp.cnt, exp.addr, exp.pe, exp.bsy, exp.rdy);
        end
    endtask

    // One clock: drive inputs, move the model across the next rising edge.
    task automatic step(input bit r, input bit e, input bit v, input int p,
                        input int d, output bit took);
        bit last;
        int ns;
        int cp;
        @(negedge Clk);
        Rst        = r;
        en         = e;
        cfg_valid  = v;
        cfg_period = CW'(p);
        cfg_duty   = CW'(d);
        took = !r && v && (m_pend == 0);
        cp   = (p < 2) ? 2 : p;
        if (r) begin
            m_state = 0; m_pos = 0; m_per = MAXV; m_duty = 0;
            m_pend = 0; m_addr = 0;
        end else if (m_state == 0) begin
            if (took) begin m_per = cp; m_duty = d; end
            if (e) begin m_state = 1; m_pos = 0; end
        end else begin
            last = (m_pos == m_per - 1);
            ns   = e ? 1 : ((m_state == 2 && last) ? 0 : 2);
            if (last) begin
                m_pos  = 0;
                m_addr = (m_addr + 1) % DEPTH;
                if (ns == 0 && took) begin
                    m_per = cp; m_duty = d;
                end else begin
                    if (m_pend != 0) begin m_per = m_sper; m_duty = m_sduty; m_pend = 0; end
                    if (took) begin m_sper = cp; m_sduty = d; m_pend = 1; end
                end
            end else begin
                m_pos++;
                if (took) begin m_sper = cp; m_sduty = d; m_pend = 1; end
            end
            m_state = ns;
        end
        exp_q.push_back(model_out());
    endtask

    task automatic run(input int n, input bit e);
        bit t;
        for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 0, 0, t);
    endtask

    task automatic offer(input int p, input int d, input bit e);
        bit t;
        t = 1'b0;
        for (int i = 0; i < 400 && !t; i++) step(1'b0, e, 1'b1, p, d, t);
        checks++;
        if (!t) begin
            failures++;
            $display("FAIL offer_timeout got accepted=0 required accepted=1");
        end
    endtask

    task automatic wait_pos(input int k);
        bit t;
        for (int i = 0; i < 400 && m_pos != k; i++) step(1'b0, 1'b1, 1'b0, 0, 0, t);
    endtask

    task automatic drain();
        bit t;
        for (int i = 0; i < 400 && m_state != 0; i++) step(1'b0, 1'b0, 1'b0, 0, 0, t);
    endtask

    // Monitor: compares the DUT against the queued expectation after each edge.
    initial begin
        snap_t got;
        snap_t exp;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = '{pwm: pwm_out, cnt: count, addr: address, pe: period_end,
                        bsy: busy, rdy: cfg_ready};
                check("cycle", got, exp);
            end
        end
    end

    initial begin
        bit t;
        bit r_en;
        // Reset, then run at the reset period with zero duty until the
        // address has wrapped past the table end.
        step(1'b1, 1'b0, 1'b0, 0, 0, t);
        step(1'b1, 1'b0, 1'b0, 0, 0, t);
        run(5, 1'b0);
        run(MAXV * DEPTH + 150, 1'b1);

        // IDLE configuration 10/3, then run.
        drain();
        offer(10, 3, 1'b0);
        run(3, 1'b0);
        run(40, 1'b1);

        // Mid-period update 8/5 offered at count 4.
        wait_pos(4);
        offer(8, 5, 1'b1);
        run(30, 1'b1);

        // Offer exactly on the period_end cycle.
        wait_pos(m_per - 1);
        offer(6, 2, 1'b1);
        run(30, 1'b1);

        // Stop request at count 2 of a 10-clock period.
        offer(10, 3, 1'b1);
        run(25, 1'b1);
        wait_pos(2);
        drain();
        run(4, 1'b0);
        // Re-enable while stopping: no gap.
        run(15, 1'b1);
        run(3, 1'b0);
        run(20, 1'b1);

        // Clamp of short periods, oversized duty.
        drain();
        offer(0, 1, 1'b0);
        run(10, 1'b1);
        offer(1, 1, 1'b1);
        run(10, 1'b1);
        offer(10, 12, 1'b1);
        run(30, 1'b1);

        // Reset mid-period with a pending update.
        wait_pos(3);
        offer(7, 2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 0, 0, t);
        run(5, 1'b0);
        run(120, 1'b1);

        // Randomized traffic.
        r_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) r_en = !r_en;
            step(($urandom_range(0, 599) == 0), r_en, ($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 20)), int'($urandom_range(0, 22)), t);
        end

        repeat (3) @(posedge Clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got pending=%0d required pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
